// File: rtl/fpu_fix_acc.sv
// fpu_fix_acc: converts a stream of single-precision products into signed
// fixed point Q(ACC_W-FRAC_W).FRAC_W and sums each burst with saturation.
//
// Handshake: i_valid marks a product on i_x for exactly one cycle. There is
// no backpressure, and one element per cycle is always accepted. i_last only
// counts when i_valid is high. o_valid is a one-cycle pulse. o_sum and o_ovf
// hold their values until the next pulse.
module fpu_fix_acc #(
  parameter int ACC_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_last,
  input  logic [31:0]      i_x,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf,
  output logic             o_busy
);

  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  // Conversion signals.
  logic             x_sgn;
  logic [7:0]       x_expn;
  logic [23:0]      x_mant;
  int               shift_s;
  int               top_pos;
  logic [23:0]      mant_rs;
  logic [ACC_W-1:0] mag;
  logic [ACC_W-1:0] conv_val;
  logic             conv_flag;

  // Stage-1 pipeline registers.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q,  s1_last_d;
  logic [ACC_W-1:0] s1_val_q,   s1_val_d;
  logic             s1_flag_q,  s1_flag_d;

  // Stage-2 state and output registers.
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             ovf_q,   ovf_d;
  logic [ACC_W-1:0] sum_q,   sum_d;
  logic             oovf_q,  oovf_d;
  logic             ovalid_q, ovalid_d;

  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic [ACC_W-1:0] add_sat;

  // Float-to-fixed conversion. top_pos is where the mantissa's leading one
  // lands. If it reaches the sign bit, the value cannot be represented.
  always_comb begin
    x_sgn     = i_x[31];
    x_expn    = i_x[30:23];
    x_mant    = {1'b1, i_x[22:0]};
    shift_s   = int'(x_expn) - 150 + FRAC_W;
    top_pos   = shift_s + 23;
    mant_rs   = '0;
    mag       = '0;
    conv_val  = '0;
    conv_flag = 1'b0;
    if (x_expn == 8'd0) begin
      conv_val = '0;
    end else if (x_expn == 8'hFF || top_pos >= ACC_W - 1) begin
      conv_val  = x_sgn ? MIN_V : MAX_V;
      conv_flag = 1'b1;
    end else begin
      if (shift_s >= 0) begin
        mag = ACC_W'(x_mant) << shift_s;
      end else begin
        mant_rs = x_mant >> (-shift_s);
        mag     = ACC_W'(mant_rs);
      end
      conv_val = x_sgn ? -mag : mag;
    end
  end

  // Stage-1 next values. A non-valid cycle never carries a last marker.
  always_comb begin
    s1_valid_d = i_valid;
    s1_last_d  = i_valid & i_last;
    s1_val_d   = conv_val;
    s1_flag_d  = i_valid & conv_flag;
  end

  // Stage-1 register. Reset drops any element in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_val_q   <= '0;
      s1_flag_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_val_q   <= s1_val_d;
      s1_flag_q  <= s1_flag_d;
    end
  end

  // Accumulator FSM: next state, saturating add, and emit on the last element.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    sum_d    = sum_q;
    oovf_d   = oovf_q;
    ovalid_d = 1'b0;
    sum_ext  = {acc_q[ACC_W-1], acc_q} + {s1_val_q[ACC_W-1], s1_val_q};
    add_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    add_sat  = add_ovf ? (sum_ext[ACC_W] ? MIN_V : MAX_V) : sum_ext[ACC_W-1:0];
    if (s1_valid_q) begin
      case (state_q)
        ST_IDLE: begin
          acc_d = s1_val_q;
          ovf_d = s1_flag_q;
        end
        default: begin
          acc_d = add_sat;
          ovf_d = ovf_q | s1_flag_q | add_ovf;
        end
      endcase
      if (s1_last_q) begin
        ovalid_d = 1'b1;
        sum_d    = acc_d;
        oovf_d   = ovf_d;
        state_d  = ST_IDLE;
      end else begin
        state_d  = ST_ACC;
      end
    end
  end

  // Stage-2 registers. Reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      sum_q    <= '0;
      oovf_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      sum_q    <= sum_d;
      oovf_q   <= oovf_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign o_valid = ovalid_q;
  assign o_sum   = sum_q;
  assign o_ovf   = oovf_q;
  assign o_busy  = (state_q == ST_ACC);

endmodule

// File: tb/tb_fpu_fix_acc.sv
// Bench for fpu_fix_acc: directed bursts with hand-computed results and
// random bursts checked against a 64-bit reference model.
module tb_fpu_fix_acc;

  localparam int     ACC_W  = 32;
  localparam int     FRAC_W = 16;
  localparam longint MAXV   = 64'sd2147483647;
  localparam longint MINV   = -64'sd2147483648;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_last = 1'b0;
  logic [31:0]       i_x = '0;
  logic              o_valid;
  logic [ACC_W-1:0]  o_sum;
  logic              o_ovf;
  logic              o_busy;

  fpu_fix_acc #(.ACC_W(ACC_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_last(i_last), .i_x(i_x),
    .o_valid(o_valid), .o_sum(o_sum), .o_ovf(o_ovf), .o_busy(o_busy)
  );

  // Scoreboard state.
  logic [32:0] exp_q[$];
  int          due_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [32:0] last_out = '0;
  bit          use_model = 1'b0;
  longint      m_acc = 0;
  bit          m_ovf = 1'b0;
  bit          m_open = 1'b0;
  bit          prev_open = 1'b0;

  // Reference conversion, done with 64-bit range checks.
  function automatic void conv_model(input logic [31:0] x, output longint v, output bit f);
    int     e;
    int     s;
    longint m;
    longint mag;
    e   = int'(x[30:23]);
    m   = longint'({1'b1, x[22:0]});
    mag = 0;
    f   = 1'b0;
    v   = 0;
    if (e == 0) return;
    if (e == 255) begin
      f = 1'b1;
    end else begin
      s = e - 150 + FRAC_W;
      if (s >= 0) begin
        if (s >= 40) f = 1'b1;
        else begin
          mag = m << s;
          if (mag > MAXV) f = 1'b1;
        end
      end else begin
        mag = (-s >= 24) ? 0 : (m >> (-s));
      end
    end
    if (f) v = x[31] ? MINV : MAXV;
    else   v = x[31] ? -mag : mag;
  endfunction

  // Queue an expected burst result for an element driven in this step.
  task automatic exp_push(input logic [31:0] s, input bit o);
    exp_q.push_back({o, s});
    due_q.push_back(cyc + 2);
  endtask

  // Driver task: drive one cycle, advance the model, then check busy, output, and hold.
  task automatic step(input bit r, input bit v, input bit l, input logic [31:0] x);
    longint      cv;
    longint      t;
    bit          cf;
    bit          cur_open;
    logic [32:0] e;
    int          d;
    rst = r; i_valid = v; i_last = l; i_x = x;
    if (r) begin
      m_open = 1'b0; m_acc = 0; m_ovf = 1'b0;
      exp_q.delete(); due_q.delete();
    end else if (v) begin
      conv_model(x, cv, cf);
      if (!m_open) begin
        m_acc = cv; m_ovf = cf;
      end else begin
        t = m_acc + cv;
        if (t > MAXV) begin t = MAXV; cf = 1'b1; end
        else if (t < MINV) begin t = MINV; cf = 1'b1; end
        m_acc = t; m_ovf = m_ovf | cf;
      end
      if (l) begin
        if (use_model) exp_push(m_acc[31:0], m_ovf);
        m_open = 1'b0;
      end else begin
        m_open = 1'b1;
      end
    end
    cur_open = m_open;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin prev_open = 1'b0; last_out = '0; end
    n_cmp++;
    if (o_busy !== prev_open) begin
      n_err++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, o_busy, prev_open);
    end
    prev_open = cur_open;
    if (o_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out cyc=%0d got sum=%h ovf=%b exp none", cyc, o_sum, o_ovf);
      end else begin
        e = exp_q.pop_front();
        d = due_q.pop_front();
        last_out = e;
        if ({o_ovf, o_sum} !== e || cyc != d) begin
          n_err++;
          $display("FAIL out cyc=%0d got sum=%h ovf=%b exp sum=%h ovf=%b due=%0d",
                   cyc, o_sum, o_ovf, e[31:0], e[32], d);
        end
      end
    end else begin
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_cmp++;
        n_err++;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        $display("FAIL missing_out cyc=%0d got o_valid=%b exp sum=%h due=%0d", cyc, o_valid, e[31:0], d);
      end
      n_cmp++;
      if ({o_ovf, o_sum} !== last_out) begin
        n_err++;
        $display("FAIL hold cyc=%0d got sum=%h ovf=%b exp sum=%h ovf=%b",
                 cyc, o_sum, o_ovf, last_out[31:0], last_out[32]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset;
    step(1'b1, 1'b1, 1'b1, 32'h3F800000);
    step(1'b1, 1'b1, 1'b0, 32'h40000000);
    n_cmp++;
    if (o_valid !== 1'b0 || o_sum !== '0 || o_ovf !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset got v=%b sum=%h ovf=%b busy=%b exp 0/0/0/0", o_valid, o_sum, o_ovf, o_busy);
    end
    idle(2);
  endtask

  task automatic test_basic;
    step(1'b0, 1'b1, 1'b0, 32'h3FC00000);
    exp_push(32'h0003C000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h40100000);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL early_valid got=%b exp=0", o_valid);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (o_valid !== 1'b1) begin
      n_err++;
      $display("FAIL latency got o_valid=%b exp=1", o_valid);
    end
    idle(3);
  endtask

  task automatic test_singles;
    exp_push(32'hFFFF8000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'hBF000000);
    exp_push(32'h00000000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h35800000);
    exp_push(32'h00000000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h00000000);
    exp_push(32'h7FFFFFFF, 1'b1); step(1'b0, 1'b1, 1'b1, 32'h7F800000);
    exp_push(32'h80000000, 1'b1); step(1'b0, 1'b1, 1'b1, 32'hFF800000);
    exp_push(32'h7FFFFFFF, 1'b1); step(1'b0, 1'b1, 1'b1, 32'h501502F9);
    exp_push(32'h00010000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h3F800000);
    idle(4);
  endtask

  task automatic test_saturation;
    step(1'b0, 1'b1, 1'b0, 32'h46800000);
    step(1'b0, 1'b1, 1'b0, 32'h46800000);
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_mid got=%b exp=1", o_busy);
    end
    exp_push(32'h7FFEFFFF, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'hBF800000);
    idle(4);
  endtask

  task automatic test_back_to_back;
    exp_push(32'h00010000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h3F800000);
    exp_push(32'h00020000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h40000000);
    exp_push(32'h00030000, 1'b0); step(1'b0, 1'b1, 1'b1, 32'h40400000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_busy i=%0d got=%b exp=0", i, o_busy);
      end
    end
  endtask

  task automatic test_idle_last;
    step(1'b0, 1'b1, 1'b0, 32'h3F800000);
    step(1'b0, 1'b0, 1'b1, 32'h41200000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    exp_push(32'h00030000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h40000000);
    idle(4);
  endtask

  task automatic test_reset_mid_burst;
    step(1'b0, 1'b1, 1'b0, 32'h3F800000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h3F800000);
    step(1'b1, 1'b1, 1'b1, 32'h3F800000);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    exp_push(32'h00040000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h40800000);
    idle(4);
  endtask

  task automatic test_random;
    logic [31:0] x;
    int          len;
    use_model = 1'b1;
    for (int b = 0; b < 30; b++) begin
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) begin
        x[31]    = 1'($urandom_range(0, 1));
        x[22:0]  = 23'($urandom);
        case ($urandom_range(0, 9))
          0:       x[30:23] = 8'd0;
          1:       x[30:23] = 8'hFF;
          2:       x[30:23] = 8'($urandom_range(155, 160));
          default: x[30:23] = 8'($urandom_range(110, 152));
        endcase
        step(1'b0, 1'b1, (k == len - 1), x);
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 32'h3F800000);
      end
    end
    idle(4);
    use_model = 1'b0;
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_basic();
    test_singles();
    test_saturation();
    test_back_to_back();
    test_idle_last();
    test_reset_mid_burst();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
